// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu_ctrl instruction sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_OPERATE   = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    // Opcode / op field values
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    // Writeback source select
    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    // ALU op codes (equal to the op field of ALU-class instructions)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Shifter op codes
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    // Instruction class flags; exactly one is set for any IR value
    typedef struct packed {
        logic is_mov_imm;
        logic is_mov_reg;
        logic is_add;
        logic is_cmp;
        logic is_and;
        logic is_mvn;
        logic is_illegal;
    } iclass_t;

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// Combinational instruction decoder: field slices, sximm8 and class flags.
module cpu_ctrl_instr_dec
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned n = 16
) (
    input  logic [n-1:0] ir,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [2:0]   rm,
    output logic [1:0]   op,
    output logic [1:0]   sh,
    output logic [n-1:0] sximm8,
    output iclass_t      cls
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(n-8){ir[7]}}, ir[7:0]};

    // Classify the instruction; anything not matched is illegal
    always_comb begin
        cls = '0;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      cls.is_mov_imm = 1'b1;
                else if (op == OP_MOV_REG) cls.is_mov_reg = 1'b1;
                else                       cls.is_illegal = 1'b1;
            end
            OPC_ALU: begin
                case (op)
                    ALU_ADD: cls.is_add = 1'b1;
                    ALU_CMP: cls.is_cmp = 1'b1;
                    ALU_AND: cls.is_and = 1'b1;
                    default: cls.is_mvn = 1'b1;
                endcase
            end
            default: cls.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM driving register file and datapath enables.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s,
    input  logic [n-1:0] instr,
    output logic         w,
    output logic         done,
    output logic         illegal,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic         loada,
    output logic         loadb,
    output logic         loadc,
    output logic         loads,
    output logic         asel,
    output logic         bsel,
    output logic [1:0]   vsel,
    output logic [1:0]   shift,
    output logic [1:0]   aluop,
    output logic [n-1:0] sximm8
);

    state_t       state;
    state_t       next_state;
    logic [n-1:0] ir;
    logic [2:0]   rn;
    logic [2:0]   rd;
    logic [2:0]   rm;
    logic [1:0]   op;
    logic [1:0]   sh;
    iclass_t      cls;

    cpu_ctrl_instr_dec #(.n(n)) u_dec (
        .ir     (ir),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .op     (op),
        .sh     (sh),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    // State register and instruction register; IR loads only on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && s) begin
                ir <= instr;
            end
        end
    end

    // Next-state and Moore outputs decoded from state and IR
    always_comb begin
        next_state = state;
        w        = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        shift    = SH_NONE;
        aluop    = ALU_ADD;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (cls.is_illegal) begin
                    done       = 1'b1;
                    illegal    = 1'b1;
                    next_state = S_WAIT;
                end else if (cls.is_mov_imm) begin
                    next_state = S_WRITE_IMM;
                end else if (cls.is_add || cls.is_cmp || cls.is_and) begin
                    next_state = S_GET_A;
                end else begin
                    next_state = S_GET_B;
                end
            end
            S_WRITE_IMM: begin
                write      = 1'b1;
                writenum   = rn;
                vsel       = VSEL_IMM;
                done       = 1'b1;
                next_state = S_WAIT;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_OPERATE;
            end
            S_OPERATE: begin
                shift = sh;
                aluop = op;
                asel  = cls.is_mov_reg || cls.is_mvn;
                if (cls.is_cmp) begin
                    loads      = 1'b1;
                    done       = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                write      = 1'b1;
                writenum   = rd;
                vsel       = VSEL_C;
                done       = 1'b1;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl.
module tb_cpu_ctrl;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w, done, illegal, write;
    logic        loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;
    logic [21:0] obs;

    int checks   = 0;
    int failures = 0;

    localparam logic [21:0] WAITV = 22'h200000;
    localparam logic [21:0] DECV  = 22'h000000;

    cpu_ctrl #(.n(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .done     (done),
        .illegal  (illegal),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .aluop    (aluop),
        .sximm8   (sximm8)
    );

    // Observed control vector; bsel expected 0 everywhere
    assign obs = {w, done, illegal, write, loada, loadb, loadc, loads, asel, bsel,
                  vsel, shift, aluop, readnum, writenum};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an expected control vector from named fields
    function automatic logic [21:0] pk(input int w_, input int dn, input int il, input int wr,
                                       input int la, input int lb, input int lc, input int ls,
                                       input int as_, input int vs, input int shf, input int al,
                                       input int rn, input int wn);
        return {1'(w_), 1'(dn), 1'(il), 1'(wr), 1'(la), 1'(lb), 1'(lc), 1'(ls), 1'(as_), 1'b0,
                2'(vs), 2'(shf), 2'(al), 3'(rn), 3'(wn)};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0000;
        #3;
        checks++;
        if (obs !== WAITV) begin
            failures++;
            $display("FAIL reset_ctrl: got %h exp %h", obs, WAITV);
        end
        checks++;
        if (sximm8 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_sximm8: got %h exp %h", sximm8, 16'h0000);
        end
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // MOV #imm twice back to back, second accepted the cycle after done
    task automatic test_mov_imm();
        logic [15:0] ins [2];
        logic [21:0] ev  [2][3];
        logic [15:0] xs  [2];
        ins = '{16'hD007, 16'hD1FE};
        xs  = '{16'h0007, 16'hFFFE};
        ev[0] = '{WAITV, DECV, pk(0,1,0,1,0,0,0,0,0,2,0,0,0,0)};
        ev[1] = '{WAITV, DECV, pk(0,1,0,1,0,0,0,0,0,2,0,0,0,1)};
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            if (k > 0) next_cycle();
            s     = 1'b1;
            instr = ins[k];
            for (int i = 0; i < 3; i++) begin
                if (i > 0) next_cycle();
                if (i == 1) s = 1'b0;
                checks++;
                if (obs !== ev[k][i]) begin
                    failures++;
                    $display("FAIL mov_imm%0d_c%0d: got %h exp %h", k, i, obs, ev[k][i]);
                end
            end
            checks++;
            if (sximm8 !== xs[k]) begin
                failures++;
                $display("FAIL mov_imm%0d_sximm8: got %h exp %h", k, sximm8, xs[k]);
            end
        end
    endtask

    task automatic test_add();
        logic [21:0] ev [6];
        ev = '{WAITV, DECV,
               pk(0,0,0,0,1,0,0,0,0,0,0,0,1,0),
               pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0),
               pk(0,0,0,0,0,0,1,0,0,0,1,0,0,0),
               pk(0,1,0,1,0,0,0,0,0,0,0,0,0,2)};
        next_cycle();
        s     = 1'b1;
        instr = 16'hA148;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) s = 1'b0;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL add_c%0d: got %h exp %h", i, obs, ev[i]);
            end
        end
    endtask

    // CMP with s held and instr changed while busy: both must be ignored
    task automatic test_cmp();
        logic [21:0] ev [5];
        ev = '{WAITV, DECV,
               pk(0,0,0,0,1,0,0,0,0,0,0,0,1,0),
               pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0),
               pk(0,1,0,0,0,0,0,1,0,0,0,1,0,0)};
        next_cycle();
        s     = 1'b1;
        instr = 16'hA900;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) instr = 16'hD0FF;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL cmp_c%0d: got %h exp %h", i, obs, ev[i]);
            end
        end
        checks++;
        if (sximm8 !== 16'h0000) begin
            failures++;
            $display("FAIL cmp_ir_hold: got %h exp %h", sximm8, 16'h0000);
        end
        s = 1'b0;
    endtask

    // MOV reg, MVN and AND: asel, shift and aluop variants
    task automatic test_alu_misc();
        logic [15:0] ins [3];
        int          len [3];
        logic [21:0] ev  [3][6];
        ins = '{16'hC092, 16'hB861, 16'hB6A7};
        len = '{5, 5, 6};
        ev[0] = '{WAITV, DECV,
                  pk(0,0,0,0,0,1,0,0,0,0,0,0,2,0),
                  pk(0,0,0,0,0,0,1,0,1,0,2,0,0,0),
                  pk(0,1,0,1,0,0,0,0,0,0,0,0,0,4),
                  DECV};
        ev[1] = '{WAITV, DECV,
                  pk(0,0,0,0,0,1,0,0,0,0,0,0,1,0),
                  pk(0,0,0,0,0,0,1,0,1,0,0,3,0,0),
                  pk(0,1,0,1,0,0,0,0,0,0,0,0,0,3),
                  DECV};
        ev[2] = '{WAITV, DECV,
                  pk(0,0,0,0,1,0,0,0,0,0,0,0,6,0),
                  pk(0,0,0,0,0,1,0,0,0,0,0,0,7,0),
                  pk(0,0,0,0,0,0,1,0,0,0,0,2,0,0),
                  pk(0,1,0,1,0,0,0,0,0,0,0,0,0,5)};
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            s     = 1'b1;
            instr = ins[k];
            for (int i = 0; i < len[k]; i++) begin
                if (i > 0) next_cycle();
                if (i == 1) s = 1'b0;
                checks++;
                if (obs !== ev[k][i]) begin
                    failures++;
                    $display("FAIL alu%0d_c%0d: got %h exp %h", k, i, obs, ev[k][i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] ins [3];
        logic [21:0] ev  [3];
        ins = '{16'hE000, 16'hC800, 16'hD800};
        ev  = '{WAITV, pk(0,1,1,0,0,0,0,0,0,0,0,0,0,0), WAITV};
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            s     = 1'b1;
            instr = ins[k];
            for (int i = 0; i < 3; i++) begin
                if (i > 0) next_cycle();
                if (i == 1) s = 1'b0;
                checks++;
                if (obs !== ev[i]) begin
                    failures++;
                    $display("FAIL illegal%0d_c%0d: got %h exp %h", k, i, obs, ev[i]);
                end
            end
        end
    endtask

    // Reset during GET_B aborts without write or done; next instruction runs clean
    task automatic test_reset_mid_op();
        logic [21:0] ev [3];
        logic [21:0] getb;
        getb = pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0);
        next_cycle();
        s     = 1'b1;
        instr = 16'hA148;
        next_cycle();
        s = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (obs !== getb) begin
            failures++;
            $display("FAIL rst_mid_getb: got %h exp %h", obs, getb);
        end
        reset = 1'b1;
        s     = 1'b1;
        instr = 16'hD0FF;
        #1;
        checks++;
        if (obs !== WAITV) begin
            failures++;
            $display("FAIL rst_mid_async: got %h exp %h", obs, WAITV);
        end
        next_cycle();
        checks++;
        if (obs !== WAITV || sximm8 !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid_hold: got %h/%h exp %h/%h", obs, sximm8, WAITV, 16'h0000);
        end
        reset = 1'b0;
        s     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            checks++;
            if (obs !== WAITV) begin
                failures++;
                $display("FAIL rst_mid_idle_c%0d: got %h exp %h", i, obs, WAITV);
            end
        end
        ev = '{WAITV, DECV, pk(0,1,0,1,0,0,0,0,0,2,0,0,0,0)};
        s     = 1'b1;
        instr = 16'hD007;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) s = 1'b0;
            checks++;
            if (obs !== ev[i]) begin
                failures++;
                $display("FAIL rst_mid_retry_c%0d: got %h exp %h", i, obs, ev[i]);
            end
        end
        checks++;
        if (sximm8 !== 16'h0007) begin
            failures++;
            $display("FAIL rst_mid_retry_sximm8: got %h exp %h", sximm8, 16'h0007);
        end
        next_cycle();
        checks++;
        if (obs !== WAITV) begin
            failures++;
            $display("FAIL rst_mid_final: got %h exp %h", obs, WAITV);
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_add();
        test_cmp();
        test_alu_misc();
        test_illegal();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
